// File: rtl/playfield_renderer.sv
// Playfield pixel stage: maps the scan position to a board tile, fetches its type
// from board RAM and emits the palette colour, with sync/blank delayed to match.
module playfield_renderer #(
    parameter int unsigned HSTART     = 240,
    parameter int unsigned HEND       = 400,
    parameter int unsigned VSTART     = 60,
    parameter int unsigned VEND       = 460,
    parameter int unsigned TILE_W     = 16,
    parameter int unsigned TILE_H     = 20,
    parameter int unsigned COLS       = 10,
    parameter logic [23:0] GRID_COLOR = 24'h20_2020
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  vga_row,
    input  logic [9:0]  vga_col,
    input  logic        vga_blank,
    input  logic        vga_hs,
    input  logic        vga_vs,
    output logic        tile_rd_en,
    output logic [7:0]  tile_rd_addr,
    input  logic [3:0]  tile_rd_data,
    output logic [23:0] rgb,
    output logic        hs_out,
    output logic        vs_out,
    output logic        blank_out
);
    localparam int unsigned TW_LOG   = $clog2(TILE_W);
    localparam int unsigned ROWS     = (VEND - VSTART) / TILE_H;
    localparam int unsigned SY_W     = $clog2(TILE_H);
    localparam int unsigned TR_W     = $clog2(ROWS);
    localparam int unsigned TC_W     = 10 - TW_LOG;
    localparam int unsigned ADDR_MAX = ROWS * COLS - 1;
    localparam logic [23:0] BG_COLOR = 24'h10_1010;

    localparam logic [3:0] T_BLANK   = 4'd0;
    localparam logic [3:0] T_GARBAGE = 4'd1;
    localparam logic [3:0] T_GHOST   = 4'd2;
    localparam logic [3:0] T_I       = 4'd3;
    localparam logic [3:0] T_O       = 4'd4;
    localparam logic [3:0] T_T       = 4'd5;
    localparam logic [3:0] T_J       = 4'd6;
    localparam logic [3:0] T_L       = 4'd7;
    localparam logic [3:0] T_S       = 4'd8;
    localparam logic [3:0] T_Z       = 4'd9;

    function automatic logic [23:0] palette(input logic [3:0] code);
        case (code)
            T_BLANK:   palette = 24'h00_0000;
            T_GARBAGE: palette = 24'hAA_AAAA;
            T_GHOST:   palette = 24'h80_8080;
            T_I:       palette = 24'h00_FDFF;
            T_O:       palette = 24'hFF_FF00;
            T_T:       palette = 24'hFF_00FF;
            T_J:       palette = 24'h00_00FF;
            T_L:       palette = 24'hFF_8000;
            T_S:       palette = 24'h00_FF00;
            T_Z:       palette = 24'hFF_0000;
            default:   palette = BG_COLOR;
        endcase
    endfunction

    // Row tracking state
    logic [9:0]      r_prev_row;
    logic [SY_W-1:0] r_sy;
    logic [TR_W-1:0] r_tile_row;
    logic            r_row_sync;

    // Pipeline stage registers
    logic r_s0_draw, r_s0_grid, r_s0_blank, r_s0_hs, r_s0_vs;
    logic r_s1_draw, r_s1_grid, r_s1_blank, r_s1_hs, r_s1_vs;

    logic [9:0]      w_col_off;
    logic [TC_W-1:0] w_tile_col;
    logic            w_in_cols;
    logic            w_in_rows;
    logic            w_in_pf;
    logic            w_new_row;
    logic            w_vstart;
    logic            w_row_sync;
    logic [SY_W-1:0] w_sy;
    logic [TR_W-1:0] w_tile_row;
    logic [8:0]      w_addr_sum;
    logic [7:0]      w_addr;
    logic            w_grid;

    // Position decode, row/sub-row counters and clamped tile address for the presented pixel
    always_comb begin
        w_col_off  = vga_col - 10'(HSTART);
        w_tile_col = TC_W'(w_col_off >> TW_LOG);
        w_in_cols  = (vga_col >= 10'(HSTART)) && (vga_col < 10'(HEND));
        w_in_rows  = (vga_row >= 10'(VSTART)) && (vga_row < 10'(VEND));
        w_in_pf    = w_in_cols && w_in_rows;
        w_new_row  = (vga_row != r_prev_row);
        w_vstart   = (vga_row == 10'(VSTART));
        w_row_sync = r_row_sync || w_vstart;
        w_sy       = r_sy;
        w_tile_row = r_tile_row;
        if (w_vstart) begin
            w_sy       = '0;
            w_tile_row = '0;
        end else if (w_new_row && r_row_sync && w_in_rows) begin
            if (r_sy == SY_W'(TILE_H - 1)) begin
                w_sy = '0;
                if (r_tile_row != TR_W'(ROWS - 1)) begin
                    w_tile_row = r_tile_row + 1'b1;
                end
            end else begin
                w_sy = r_sy + 1'b1;
            end
        end
        w_addr_sum = (9'(w_tile_row) << 3) + (9'(w_tile_row) << 1) + 9'(w_tile_col);
        w_addr     = (w_addr_sum > 9'(ADDR_MAX)) ? 8'(ADDR_MAX) : 8'(w_addr_sum);
        w_grid     = (w_col_off[TW_LOG-1:0] == '0) || (w_sy == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev_row <= '0;
            r_sy       <= '0;
            r_tile_row <= '0;
            r_row_sync <= 1'b0;
        end else begin
            r_prev_row <= vga_row;
            r_sy       <= w_sy;
            r_tile_row <= w_tile_row;
            r_row_sync <= w_row_sync;
        end
    end

    // S0: read request plus per-pixel flags; syncs idle high and blank asserted in reset
    always_ff @(posedge clk) begin
        if (rst) begin
            tile_rd_en   <= 1'b0;
            tile_rd_addr <= '0;
            r_s0_draw    <= 1'b0;
            r_s0_grid    <= 1'b0;
            r_s0_blank   <= 1'b1;
            r_s0_hs      <= 1'b1;
            r_s0_vs      <= 1'b1;
        end else begin
            tile_rd_en   <= w_in_pf && w_row_sync && !vga_blank;
            tile_rd_addr <= w_addr;
            r_s0_draw    <= w_in_pf && w_row_sync;
            r_s0_grid    <= w_grid;
            r_s0_blank   <= vga_blank;
            r_s0_hs      <= vga_hs;
            r_s0_vs      <= vga_vs;
        end
    end

    // S1: flags wait while the RAM returns the tile type
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_draw  <= 1'b0;
            r_s1_grid  <= 1'b0;
            r_s1_blank <= 1'b1;
            r_s1_hs    <= 1'b1;
            r_s1_vs    <= 1'b1;
        end else begin
            r_s1_draw  <= r_s0_draw;
            r_s1_grid  <= r_s0_grid;
            r_s1_blank <= r_s0_blank;
            r_s1_hs    <= r_s0_hs;
            r_s1_vs    <= r_s0_vs;
        end
    end

    // S2: colour select in priority order
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb       <= '0;
            hs_out    <= 1'b1;
            vs_out    <= 1'b1;
            blank_out <= 1'b1;
        end else begin
            hs_out    <= r_s1_hs;
            vs_out    <= r_s1_vs;
            blank_out <= r_s1_blank;
            if (r_s1_blank) begin
                rgb <= 24'h00_0000;
            end else if (!r_s1_draw) begin
                rgb <= BG_COLOR;
            end else if ((tile_rd_data == T_BLANK) && r_s1_grid) begin
                rgb <= GRID_COLOR;
            end else begin
                rgb <= palette(tile_rd_data);
            end
        end
    end
endmodule

// File: tb/tb_playfield_renderer.sv
// Bench for playfield_renderer: compressed raster frames against a board RAM model,
// with hand-computed checks at the corner, grid, illegal-code and off-playfield pixels.
module tb_playfield_renderer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  vga_row = '0;
    logic [9:0]  vga_col = '0;
    logic        vga_blank = 1'b1;
    logic        vga_hs = 1'b1;
    logic        vga_vs = 1'b1;
    logic        tile_rd_en;
    logic [7:0]  tile_rd_addr;
    logic [3:0]  tile_rd_data = '0;
    logic [23:0] rgb;
    logic        hs_out, vs_out, blank_out;

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0] mem [200];

    typedef struct packed {
        logic        hand;
        logic [23:0] rgb;
        logic        hs;
        logic        vs;
        logic        blank;
        logic        en;
        logic [7:0]  addr;
    } exp_t;

    localparam exp_t INV = '{hand: 1'b0, rgb: 24'h0, hs: 1'b1, vs: 1'b1, blank: 1'b1, en: 1'b0, addr: 8'h0};

    exp_t q0 = INV, q1 = INV, q2 = INV;
    bit   m_sync = 1'b0;

    // Hand-computed vectors: row, col, read enable, address, colour
    localparam int NH = 6;
    int          h_row  [NH] = '{60, 459, 80, 81, 30, 170};
    int          h_col  [NH] = '{241, 399, 256, 257, 100, 325};
    bit          h_en   [NH] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    int          h_addr [NH] = '{0, 199, 11, 11, 0, 55};
    logic [23:0] h_rgb  [NH] = '{24'h00fdff, 24'hff0000, 24'h202020, 24'h000000, 24'h101010, 24'h101010};

    int cols [16] = '{0, 100, 239, 240, 241, 255, 256, 257, 300, 320, 325, 336, 399, 400, 639, 700};

    playfield_renderer dut (
        .clk          (clk),
        .rst          (rst),
        .vga_row      (vga_row),
        .vga_col      (vga_col),
        .vga_blank    (vga_blank),
        .vga_hs       (vga_hs),
        .vga_vs       (vga_vs),
        .tile_rd_en   (tile_rd_en),
        .tile_rd_addr (tile_rd_addr),
        .tile_rd_data (tile_rd_data),
        .rgb          (rgb),
        .hs_out       (hs_out),
        .vs_out       (vs_out),
        .blank_out    (blank_out)
    );

    always #5 clk = ~clk;

    // Board RAM: one-cycle read latency
    always @(posedge clk) begin
        if (tile_rd_en) tile_rd_data <= mem[tile_rd_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s row=%0d col=%0d: got %h expected %h", tag, vga_row, vga_col, got, exp);
        end
    endtask

    function automatic logic [23:0] pal(input logic [3:0] code);
        case (code)
            4'd0: return 24'h000000;
            4'd1: return 24'haaaaaa;
            4'd2: return 24'h808080;
            4'd3: return 24'h00fdff;
            4'd4: return 24'hffff00;
            4'd5: return 24'hff00ff;
            4'd6: return 24'h0000ff;
            4'd7: return 24'hff8000;
            4'd8: return 24'h00ff00;
            4'd9: return 24'hff0000;
            default: return 24'h101010;
        endcase
    endfunction

    // Check outputs due now, then present one pixel and queue its expectation
    task automatic px(input int r, input int c, input bit rs);
        exp_t e;
        bit   inpf;
        int   ad;
        logic [3:0] code;
        @(negedge clk);
        check(q2.hand ? "rgb_directed" : "rgb", 32'(rgb), 32'(q2.rgb));
        check("hs_out", 32'(hs_out), 32'(q2.hs));
        check("vs_out", 32'(vs_out), 32'(q2.vs));
        check("blank_out", 32'(blank_out), 32'(q2.blank));
        check(q0.hand ? "rd_en_directed" : "rd_en", 32'(tile_rd_en), 32'(q0.en));
        if (q0.en) check(q0.hand ? "rd_addr_directed" : "rd_addr", 32'(tile_rd_addr), 32'(q0.addr));
        q2 = q1;
        q1 = q0;

        rst       = rs;
        vga_row   = 10'(r);
        vga_col   = 10'(c);
        vga_blank = (r >= 480) || (c >= 640);
        vga_hs    = !((c >= 656) && (c < 752));
        vga_vs    = !((r == 490) || (r == 491));

        if (rs) begin
            m_sync = 1'b0;
            q0 = INV; q1 = INV; q2 = INV;
            return;
        end
        if (r == 60) m_sync = 1'b1;

        inpf    = (c >= 240) && (c < 400) && (r >= 60) && (r < 460);
        e.hand  = 1'b0;
        e.hs    = vga_hs;
        e.vs    = vga_vs;
        e.blank = vga_blank;
        e.en    = inpf && m_sync && !vga_blank;
        ad      = inpf ? ((r - 60) / 20) * 10 + (c - 240) / 16 : 0;
        e.addr  = 8'(ad);
        code    = mem[ad];
        if (vga_blank)            e.rgb = 24'h000000;
        else if (!(inpf && m_sync)) e.rgb = 24'h101010;
        else if (code == 4'd0 && (((c - 240) % 16) == 0 || ((r - 60) % 20) == 0)) e.rgb = 24'h202020;
        else                      e.rgb = pal(code);

        for (int i = 0; i < NH; i++) begin
            if (r == h_row[i] && c == h_col[i] && (m_sync || !h_en[i])) begin
                e.hand = 1'b1;
                e.en   = h_en[i];
                e.addr = 8'(h_addr[i]);
                e.rgb  = h_rgb[i];
            end
        end
        q0 = e;
    endtask

    initial begin
        for (int i = 0; i < 200; i++) mem[i] = 4'd0;
        mem[0]   = 4'd3;
        mem[199] = 4'd9;
        mem[55]  = 4'hC;
        for (int k = 0; k < 10; k++) mem[20 + k] = 4'(k);
        mem[13]  = 4'd4;
        mem[16]  = 4'd8;

        // Reset with random inputs
        px(int'($urandom_range(0, 524)), int'($urandom_range(0, 799)), 1'b1);
        px(int'($urandom_range(0, 524)), int'($urandom_range(0, 799)), 1'b1);

        // Frame 1: full rows, sampled columns
        for (int r = 0; r < 525; r++)
            for (int j = 0; j < 16; j++) px(r, cols[j], 1'b0);

        // Frame 2: reset at row 200 for two cycles
        for (int r = 0; r < 525; r++)
            for (int j = 0; j < 16; j++) px(r, cols[j], (r == 200) && (j < 2));

        // Frame 3: recovery from row 60
        for (int r = 0; r < 200; r++)
            for (int j = 0; j < 16; j++) px(r, cols[j], 1'b0);

        // Flush the pipeline
        for (int k = 0; k < 4; k++) px(0, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/playfield_renderer.md
# playfield_renderer

Pixel-pipeline stage between the VGA timing generator and the VGA DAC/output pins. It takes the current scan position and maps pixels inside the playfield window to a tile index. It reads that tile's `tile_type_t` from the playfield board RAM and emits the 24-bit colour from the `DisplayPkg` palette. Sync and blank signals are delayed so they stay aligned with the RGB output.

## Interface
Parameters (defaults from `DisplayPkg`):
- `HSTART`, 240, first playfield column (inclusive)
- `HEND`, 400, playfield column end (exclusive)
- `VSTART`, 60, first playfield row (inclusive)
- `VEND`, 460, playfield row end (exclusive)
- `TILE_W`, 16, tile width in pixels
- `TILE_H`, 20, tile height in pixels
- `COLS`, 10, tiles per row
- `GRID_COLOR`, 24'h20_2020, gridline colour drawn on BLANK tiles

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  pixel clock; one pixel presented per cycle
- `rst`  in  1  synchronous active-high reset
- `vga_row`  in  10  scan row of the presented pixel
- `vga_col`  in  10  scan column of the presented pixel
- `vga_blank`  in  1  1 = outside the visible area
- `vga_hs`  in  1  horizontal sync, active-low
- `vga_vs`  in  1  vertical sync, active-low
- `tile_rd_en`  out  1  board RAM read strobe
- `tile_rd_addr`  out  8  tile index `tile_row*COLS + tile_col`, range 0..199
- `tile_rd_data`  in  4  `tile_type_t`, valid exactly 1 cycle after `tile_rd_en`
- `rgb`  out  24  pixel colour
- `hs_out`  out  1  `vga_hs` delayed to align with `rgb`
- `vs_out`  out  1  `vga_vs` delayed to align with `rgb`
- `blank_out`  out  1  `vga_blank` delayed to align with `rgb`

## Operation
- A pixel is in the playfield (`in_pf`) when `HSTART<=col<HEND` and `VSTART<=row<VEND`.
- Tile position:
  - `tile_col = (col-HSTART)/TILE_W`, `sx = (col-HSTART)%TILE_W`.
  - `tile_row = (row-VSTART)/TILE_H`, `sy = (row-VSTART)%TILE_H`.
- No dividers or multipliers for `/TILE_H` or `%TILE_H`. Row and vertical sub-position are held in counters:
  - Loaded with 0 when a new row equal to `VSTART` is seen.
  - Advanced once per row change inside the window; `sy` wraps at `TILE_H-1` and increments `tile_row`.
  - Column uses a shift/mask or an equivalent counter. The address uses shift-add (`*10 = <<3 + <<1`).
- `row_sync` flag:
  - Cleared by reset; set when row `VSTART` is seen.
  - While clear, `in_pf` pixels render `BG_COLOR` and `tile_rd_en` stays 0.
- Read strobe: `tile_rd_en = in_pf & row_sync & ~vga_blank`.
- Colour select, in priority order:
  1. `blank` → 24'h000000.
  2. Not `in_pf` → `BG_COLOR` (24'h101010).
  3. Tile BLANK with `sx==0` or `sy==0` → `GRID_COLOR`.
  4. Otherwise the palette colour:
     - BLANK 000000, GARBAGE aaaaaa, GHOST 808080
     - I 00fdff, O ffff00, T ff00ff, J 0000ff
     - L ff8000, S 00ff00, Z ff0000
  5. Codes 10–15 → `BG_COLOR`.
- Scan order is monotonic raster. A non-sequential row jump gives undefined tiles until the next `VSTART` row. This must never produce an address >199; clamp to 199.

## Timing
- Pipeline:
  - S0 registers inputs and counters at t+1.
  - `tile_rd_en`/`tile_rd_addr` are registered outputs valid at t+1.
  - `tile_rd_data` is valid at t+2.
  - `rgb`/`hs_out`/`vs_out`/`blank_out` are registered and valid at t+3.
- Total latency is 3 cycles for every pixel, in or out of the playfield.
- The pipeline is fully streaming: throughput 1 pixel/cycle, no stalls, no backpressure.
- `in_pf`, `sx`, `sy` and `blank` travel with the pixel through every stage.
- Reset values:
  - `rgb` = 0, `tile_rd_en` = 0, `tile_rd_addr` = 0.
  - `hs_out` = 1, `vs_out` = 1, `blank_out` = 1.
  - All pipeline valid/flags and counters = 0; `row_sync` = 0.
- Reset asserted mid-frame: outputs take reset values on the next edge. Normal operation resumes from the first row-`VSTART` pixel after deassert.

## Test plan
- **Reset:** assert `rst` for 2 cycles with random inputs → `rgb`=0, `hs_out`=`vs_out`=`blank_out`=1, `tile_rd_en`=0.
- **Corner tiles:** full frame with an RAM model returning I at addr 0, Z at addr 199, BLANK elsewhere.
  - Pixel (60,241) → `tile_rd_addr`=0 at t+1; `rgb`=00fdff at t+3.
  - Pixel (459,399) → addr 199; `rgb`=ff0000.
- **Grid on BLANK tile:**
  - Pixel (80,256) → addr 11, `sy`=0 → `rgb`=202020.
  - Pixel (81,257) → `rgb`=000000.
- **Outside and blank:**
  - Pixel (30,100) → `rgb`=101010, `tile_rd_en`=0.
  - Any pixel with `vga_blank`=1 → `rgb`=000000, `blank_out`=1 at t+3; syncs delayed exactly 3 cycles.
- **Mid-frame reset:** reset at row 200 → playfield pixels render 101010 with `tile_rd_en`=0 until row 60 of the next frame, then match the expected tiles.
- **Illegal code:** RAM returns 4'hC at addr 55 → pixels in tile (5,5) render 101010.
